// File: rtl/wave_ctrl_if.sv
// Row-facing bus of the wave controller: per-row scores and gameover flags come in,
// vertical offsets and the respawn pulse go out.
interface wave_ctrl_if;
   logic [4:0] score_row0;
   logic [4:0] score_row1;
   logic [4:0] score_row2;
   logic [4:0] score_row3;
   logic       gameover_in;
   logic [9:0] y_offset0;
   logic [9:0] y_offset1;
   logic [9:0] y_offset2;
   logic [9:0] y_offset3;
   logic       row_reset;

   modport master (
      input  score_row0, score_row1, score_row2, score_row3, gameover_in,
      output y_offset0, y_offset1, y_offset2, y_offset3, row_reset
   );

   modport slave (
      output score_row0, score_row1, score_row2, score_row3, gameover_in,
      input  y_offset0, y_offset1, y_offset2, y_offset3, row_reset
   );
endinterface

// File: rtl/wave_ctrl.sv
// Enemy wave sequencer: marches four rows downward on frame ticks, detects wave clear
// and defeat, and keeps the wave number and banked score.
module wave_ctrl #(
   parameter logic [9:0] TOP_Y     = 10'd40,
   parameter logic [9:0] ROW_PITCH = 10'd40,
   parameter logic [9:0] FLOOR_Y   = 10'd440,
   parameter logic [4:0] ROW_SHIPS = 5'd6
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_clk,
   input  logic               play,
   input  logic               done,
   wave_ctrl_if.master        rows,
   output logic [3:0]         wave,
   output logic [11:0]        total_score,
   output logic               gameover,
   output logic               wave_done
);

   typedef enum logic [2:0] {IDLE, SPAWN, MARCH, PAUSE, CLEARED, LOST} state_t;

   localparam logic [9:0]       Y_INIT0   = TOP_Y;
   localparam logic [9:0]       Y_INIT1   = TOP_Y + ROW_PITCH;
   localparam logic [9:0]       Y_INIT2   = TOP_Y + ROW_PITCH + ROW_PITCH;
   localparam logic [9:0]       Y_INIT3   = TOP_Y + ROW_PITCH + ROW_PITCH + ROW_PITCH;
   localparam logic [3:0][9:0]  Y_INIT    = {Y_INIT3, Y_INIT2, Y_INIT1, Y_INIT0};
   localparam logic [12:0]      BANK_STEP = {6'd0, ROW_SHIPS, 2'b00};

   state_t          state_q, state_d;
   logic [3:0][9:0] y_q, y_d;
   logic [4:0]      tick_cnt_q, tick_cnt_d;
   logic [3:0]      wave_q, wave_d;
   logic [11:0]     bank_q, bank_d;
   logic            gameover_q, gameover_d;
   logic            row_reset_q, row_reset_d;
   logic            wave_done_q, wave_done_d;
   logic            sync1_q, sync2_q, sync3_q;

   logic            tick;
   logic [4:0]      period;
   logic [4:0]      cnt_inc;
   logic            all_cleared;
   logic            lose_cond;
   logic [12:0]     bank_sum;
   logic [12:0]     row_sum;
   logic [12:0]     total_sum;

   // sync3_q only remembers the previous synchronized level for edge detection
   assign tick        = sync2_q & ~sync3_q;
   assign period      = 5'd16 - {1'b0, wave_q};
   assign cnt_inc     = tick_cnt_q + 5'd1;
   assign all_cleared = (rows.score_row0 == ROW_SHIPS) && (rows.score_row1 == ROW_SHIPS) &&
                        (rows.score_row2 == ROW_SHIPS) && (rows.score_row3 == ROW_SHIPS);
   assign lose_cond   = rows.gameover_in || (y_q[3] >= FLOOR_Y);
   assign bank_sum    = {1'b0, bank_q} + BANK_STEP;
   assign row_sum     = {8'd0, rows.score_row0} + {8'd0, rows.score_row1} +
                        {8'd0, rows.score_row2} + {8'd0, rows.score_row3};
   assign total_sum   = {1'b0, bank_q} + row_sum;

   always_comb begin
      state_d     = state_q;
      y_d         = y_q;
      tick_cnt_d  = tick_cnt_q;
      wave_d      = wave_q;
      bank_d      = bank_q;
      gameover_d  = gameover_q;
      row_reset_d = 1'b0;
      wave_done_d = 1'b0;

      if (done) begin
         state_d     = IDLE;
         y_d         = Y_INIT;
         tick_cnt_d  = 5'd0;
         wave_d      = 4'd0;
         bank_d      = 12'd0;
         gameover_d  = 1'b0;
         row_reset_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               y_d = Y_INIT;
               if (play) begin
                  state_d     = SPAWN;
                  row_reset_d = 1'b1;
               end
            end
            SPAWN: begin
               y_d        = Y_INIT;
               tick_cnt_d = 5'd0;
               state_d    = MARCH;
            end
            MARCH: begin
               // Exits take priority, so a tick landing on an exit cycle is dropped
               if (lose_cond) begin
                  state_d    = LOST;
                  gameover_d = 1'b1;
               end else if (all_cleared) begin
                  state_d     = CLEARED;
                  wave_done_d = 1'b1;
               end else if (!play) begin
                  state_d = PAUSE;
               end else if (tick) begin
                  if (cnt_inc == period) begin
                     tick_cnt_d = 5'd0;
                     for (int i = 0; i < 4; i++) begin
                        if (y_q[i] != 10'h3FF) begin
                           y_d[i] = y_q[i] + 10'd1;
                        end
                     end
                  end else begin
                     tick_cnt_d = cnt_inc;
                  end
               end
            end
            PAUSE: begin
               if (play) begin
                  state_d = MARCH;
               end
            end
            CLEARED: begin
               wave_d      = (wave_q == 4'd15) ? 4'd15 : wave_q + 4'd1;
               bank_d      = bank_sum[12] ? 12'hFFF : bank_sum[11:0];
               state_d     = SPAWN;
               row_reset_d = 1'b1;
            end
            LOST: begin
               gameover_d = 1'b1;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         y_q         <= Y_INIT;
         tick_cnt_q  <= 5'd0;
         wave_q      <= 4'd0;
         bank_q      <= 12'd0;
         gameover_q  <= 1'b0;
         row_reset_q <= 1'b0;
         wave_done_q <= 1'b0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sync3_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         y_q         <= y_d;
         tick_cnt_q  <= tick_cnt_d;
         wave_q      <= wave_d;
         bank_q      <= bank_d;
         gameover_q  <= gameover_d;
         row_reset_q <= row_reset_d;
         wave_done_q <= wave_done_d;
         sync1_q     <= frame_clk;
         sync2_q     <= sync1_q;
         sync3_q     <= sync2_q;
      end
   end

   assign rows.y_offset0 = y_q[0];
   assign rows.y_offset1 = y_q[1];
   assign rows.y_offset2 = y_q[2];
   assign rows.y_offset3 = y_q[3];
   assign rows.row_reset = row_reset_q;
   assign wave           = wave_q;
   assign gameover       = gameover_q;
   assign wave_done      = wave_done_q;
   assign total_score    = total_sum[12] ? 12'hFFF : total_sum[11:0];

endmodule

// File: tb/tb_wave_ctrl.sv
// Self-checking bench for wave_ctrl: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a behavioural game model.
module tb_wave_ctrl;

   localparam int TOP   = 40;
   localparam int PITCH = 40;
   localparam int FLOOR = 440;
   localparam int SHIPS = 6;

   localparam int PH_IDLE    = 10;
   localparam int PH_SPAWN   = 11;
   localparam int PH_MARCH   = 12;
   localparam int PH_PAUSE   = 13;
   localparam int PH_CLEARED = 14;
   localparam int PH_LOST    = 15;

   typedef struct {
      bit         play;
      bit         done_pulse;
      bit         gin;
      bit         set_score;
      logic [4:0] score;
      int         edges;
      int         extra;
      int         exp_y0;
      int         exp_wave;
      bit         exp_gameover;
      int         exp_total;
   } vec_t;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        frame_clk;
   logic        play;
   logic        done;
   logic [3:0]  wave;
   logic [11:0] total_score;
   logic        gameover;
   logic        wave_done;

   wave_ctrl_if rows();

   wave_ctrl dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_clk   (frame_clk),
      .play        (play),
      .done        (done),
      .rows        (rows),
      .wave        (wave),
      .total_score (total_score),
      .gameover    (gameover),
      .wave_done   (wave_done)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit auto_rows;

   // Behavioural model: offsets are the spawn positions plus a single step count
   int m_phase, m_steps, m_cnt, m_wave, m_bank;
   bit m_gameover, m_row_reset, m_wave_done;
   bit f1, f2, f3;

   vec_t vecs[13];

   function automatic int exp_y(int n);
      int v;
      v = TOP + n * PITCH + m_steps;
      return (v > 1023) ? 1023 : v;
   endfunction

   function automatic int exp_total();
      int v;
      v = m_bank + int'(rows.score_row0) + int'(rows.score_row1) +
          int'(rows.score_row2) + int'(rows.score_row3);
      return (v > 4095) ? 4095 : v;
   endfunction

   task automatic model_step();
      bit tk;
      bit all_six;
      tk = f2 && !f3;
      all_six = (rows.score_row0 == SHIPS) && (rows.score_row1 == SHIPS) &&
                (rows.score_row2 == SHIPS) && (rows.score_row3 == SHIPS);
      if (Reset) begin
         f1 = 0; f2 = 0; f3 = 0;
         m_phase = PH_IDLE; m_steps = 0; m_cnt = 0; m_wave = 0; m_bank = 0;
         m_gameover = 0; m_row_reset = 0; m_wave_done = 0;
         return;
      end
      f3 = f2; f2 = f1; f1 = frame_clk;
      m_row_reset = 0;
      m_wave_done = 0;
      if (done) begin
         m_phase = PH_IDLE; m_steps = 0; m_cnt = 0; m_wave = 0; m_bank = 0;
         m_gameover = 0; m_row_reset = 1;
         return;
      end
      case (m_phase)
         PH_IDLE: begin
            m_steps = 0;
            if (play) begin
               m_phase = PH_SPAWN;
               m_row_reset = 1;
            end
         end
         PH_SPAWN: begin
            m_steps = 0;
            m_cnt = 0;
            m_phase = PH_MARCH;
         end
         PH_MARCH: begin
            if (rows.gameover_in || exp_y(3) >= FLOOR) begin
               m_phase = PH_LOST;
               m_gameover = 1;
            end else if (all_six) begin
               m_phase = PH_CLEARED;
               m_wave_done = 1;
            end else if (!play) begin
               m_phase = PH_PAUSE;
            end else if (tk) begin
               m_cnt++;
               if (m_cnt == 16 - m_wave) begin
                  m_cnt = 0;
                  m_steps++;
               end
            end
         end
         PH_PAUSE: begin
            if (play) m_phase = PH_MARCH;
         end
         PH_CLEARED: begin
            m_wave = (m_wave >= 15) ? 15 : m_wave + 1;
            m_bank = (m_bank + 4 * SHIPS > 4095) ? 4095 : m_bank + 4 * SHIPS;
            m_phase = PH_SPAWN;
            m_row_reset = 1;
         end
         default: begin
         end
      endcase
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
      end
   endtask

   task automatic checkOutput();
      checkVal("y_offset0",   32'(rows.y_offset0), 32'(exp_y(0)));
      checkVal("y_offset1",   32'(rows.y_offset1), 32'(exp_y(1)));
      checkVal("y_offset2",   32'(rows.y_offset2), 32'(exp_y(2)));
      checkVal("y_offset3",   32'(rows.y_offset3), 32'(exp_y(3)));
      checkVal("row_reset",   32'(rows.row_reset), 32'(m_row_reset));
      checkVal("wave_done",   32'(wave_done),      32'(m_wave_done));
      checkVal("wave",        32'(wave),           32'(m_wave));
      checkVal("gameover",    32'(gameover),       32'(m_gameover));
      checkVal("total_score", 32'(total_score),    32'(exp_total()));
   endtask

   task automatic set_scores(input logic [4:0] s);
      rows.score_row0 = s;
      rows.score_row1 = s;
      rows.score_row2 = s;
      rows.score_row3 = s;
   endtask

   // One clock: advance the model on the edge, compare just after, then emulate row respawn
   task automatic applyStimulus();
      @(posedge Clk);
      model_step();
      #1;
      checkOutput();
      if (auto_rows && m_row_reset) set_scores(5'd0);
   endtask

   task automatic frame_pulse();
      frame_clk = 1'b1;
      applyStimulus();
      applyStimulus();
      frame_clk = 1'b0;
      applyStimulus();
      applyStimulus();
   endtask

   initial begin
      int r;
      Reset = 1'b1; frame_clk = 1'b0; play = 1'b0; done = 1'b0;
      rows.gameover_in = 1'b0;
      set_scores(5'd0);
      auto_rows = 1'b1;
      m_phase = PH_IDLE; m_steps = 0; m_cnt = 0; m_wave = 0; m_bank = 0;
      m_gameover = 0; m_row_reset = 0; m_wave_done = 0;
      f1 = 0; f2 = 0; f3 = 0;

      applyStimulus();
      applyStimulus();
      Reset = 1'b0;
      checkVal("reset_y0", 32'(rows.y_offset0), 32'd40);
      checkVal("reset_y1", 32'(rows.y_offset1), 32'd80);
      checkVal("reset_y2", 32'(rows.y_offset2), 32'd120);
      checkVal("reset_y3", 32'(rows.y_offset3), 32'd160);
      checkVal("reset_wave", 32'(wave), 32'd0);
      checkVal("reset_gameover", 32'(gameover), 32'd0);
      checkVal("reset_row_reset", 32'(rows.row_reset), 32'd0);

      //        play done gin set score edges extra y0 wave go total
      vecs[0]  = '{1, 0, 0, 0, 5'd0,  0, 3, 40, 0, 0,  0};
      vecs[1]  = '{1, 0, 0, 0, 5'd0, 15, 0, 40, 0, 0,  0};
      vecs[2]  = '{1, 0, 0, 0, 5'd0,  1, 0, 41, 0, 0,  0};
      vecs[3]  = '{1, 0, 0, 0, 5'd0,  1, 0, 41, 0, 0,  0};
      vecs[4]  = '{0, 0, 0, 0, 5'd0, 10, 0, 41, 0, 0,  0};
      vecs[5]  = '{1, 0, 0, 0, 5'd0, 14, 0, 41, 0, 0,  0};
      vecs[6]  = '{1, 0, 0, 0, 5'd0,  1, 0, 42, 0, 0,  0};
      vecs[7]  = '{1, 0, 0, 1, 5'd6,  0, 4, 40, 1, 0, 24};
      vecs[8]  = '{1, 0, 0, 0, 5'd0, 14, 0, 40, 1, 0, 24};
      vecs[9]  = '{1, 0, 0, 0, 5'd0,  1, 0, 41, 1, 0, 24};
      vecs[10] = '{1, 0, 1, 1, 5'd6,  0, 3, 41, 1, 1, 48};
      vecs[11] = '{1, 0, 0, 0, 5'd0,  3, 0, 41, 1, 1, 48};
      vecs[12] = '{0, 1, 0, 0, 5'd0,  0, 2, 40, 0, 0,  0};

      for (int i = 0; i < 13; i++) begin
         play = vecs[i].play;
         rows.gameover_in = vecs[i].gin;
         if (vecs[i].set_score) set_scores(vecs[i].score);
         if (vecs[i].done_pulse) begin
            done = 1'b1;
            applyStimulus();
            done = 1'b0;
         end
         repeat (vecs[i].edges) frame_pulse();
         repeat (vecs[i].extra) applyStimulus();
         checkVal($sformatf("vec%0d_y0", i), 32'(rows.y_offset0), 32'(vecs[i].exp_y0));
         checkVal($sformatf("vec%0d_y3", i), 32'(rows.y_offset3), 32'(vecs[i].exp_y0 + 120));
         checkVal($sformatf("vec%0d_wave", i), 32'(wave), 32'(vecs[i].exp_wave));
         checkVal($sformatf("vec%0d_gameover", i), 32'(gameover), 32'(vecs[i].exp_gameover));
         checkVal($sformatf("vec%0d_total", i), 32'(total_score), 32'(vecs[i].exp_total));
      end

      // Reset together with done in the middle of a march: no respawn pulse
      play = 1'b1;
      repeat (3) applyStimulus();
      repeat (20) frame_pulse();
      Reset = 1'b1; done = 1'b1;
      applyStimulus();
      Reset = 1'b0; done = 1'b0; play = 1'b0;
      checkVal("rst_march_row_reset", 32'(rows.row_reset), 32'd0);
      checkVal("rst_march_y0", 32'(rows.y_offset0), 32'd40);

      // Reset while lost
      play = 1'b1;
      repeat (3) applyStimulus();
      rows.gameover_in = 1'b1;
      repeat (2) applyStimulus();
      rows.gameover_in = 1'b0;
      checkVal("lost_gameover", 32'(gameover), 32'd1);
      Reset = 1'b1;
      applyStimulus();
      Reset = 1'b0; play = 1'b0;
      checkVal("rst_lost_gameover", 32'(gameover), 32'd0);
      checkVal("rst_lost_row_reset", 32'(rows.row_reset), 32'd0);
      checkVal("rst_lost_wave_done", 32'(wave_done), 32'd0);

      // Clear waves back to back until wave and bank both saturate
      auto_rows = 1'b0;
      play = 1'b1;
      set_scores(5'd6);
      repeat (600) applyStimulus();
      checkVal("sat_wave", 32'(wave), 32'd15);
      checkVal("sat_total", 32'(total_score), 32'd4095);
      set_scores(5'd0);
      repeat (4) applyStimulus();
      checkVal("sat_bank_total", 32'(total_score), 32'd4095);
      frame_pulse();
      checkVal("period1_y0", 32'(rows.y_offset0), 32'd41);
      repeat (279) frame_pulse();
      checkVal("floor_y3", 32'(rows.y_offset3), 32'd440);
      checkVal("floor_gameover", 32'(gameover), 32'd1);
      repeat (3) frame_pulse();
      checkVal("floor_frozen_y3", 32'(rows.y_offset3), 32'd440);
      play = 1'b0;
      done = 1'b1;
      applyStimulus();
      done = 1'b0;
      checkVal("done_wave", 32'(wave), 32'd0);
      checkVal("done_row_reset", 32'(rows.row_reset), 32'd1);
      checkVal("done_total", 32'(total_score), 32'd0);
      applyStimulus();
      checkVal("done_row_reset_single", 32'(rows.row_reset), 32'd0);

      // Randomized play against the model
      auto_rows = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(0, 999));
         Reset = (r < 3);
         done = (r >= 3 && r < 10);
         play = ($urandom_range(0, 9) != 0);
         rows.gameover_in = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
         if ($urandom_range(0, 49) == 0) begin
            set_scores(5'd6);
         end else if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 3))
               0: rows.score_row0 = 5'($urandom_range(0, 6));
               1: rows.score_row1 = 5'($urandom_range(0, 6));
               2: rows.score_row2 = 5'($urandom_range(0, 6));
               default: rows.score_row3 = 5'($urandom_range(0, 6));
            endcase
         end
         applyStimulus();
      end
      Reset = 1'b0; done = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
